// File: rtl/rect_pkg.sv
// rtl/rect_pkg.sv - shared defaults, rectangle count, coordinate type and FSM states
package rect_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    // Each rectangle is an unordered pair of rows times an unordered pair of columns.
    function automatic int num_rects(input int rows, input int cols);
        return ((rows * (rows - 1)) / 2) * ((cols * (cols - 1)) / 2);
    endfunction

    localparam int NUM_RECTS = num_rects(DEF_ROWS, DEF_COLS);
    localparam int COORD_W   = $clog2((DEF_ROWS > DEF_COLS) ? DEF_ROWS : DEF_COLS);

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_mask.sv
// rtl/rect_mask.sv - four-corner bit mask for rectangle (r1,r2,c1,c2)
module rect_mask #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = 2,
    parameter int CW   = 2
) (
    input  logic [RW-1:0]        r1,
    input  logic [RW-1:0]        r2,
    input  logic [CW-1:0]        c1,
    input  logic [CW-1:0]        c2,
    output logic [ROWS*COLS-1:0] mask
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign mask[r*COLS+c] = ((r1 == RW'(r)) || (r2 == RW'(r))) &&
                                    ((c1 == CW'(c)) || (c2 == CW'(c)));
        end
    end

endmodule

// File: rtl/rect_scan_ctrl.sv
// rtl/rect_scan_ctrl.sv - scans every axis-aligned rectangle of a bit matrix, counting (and optionally flipping) full-corner hits
module rect_scan_ctrl
    import rect_pkg::*;
#(
    parameter int  ROWS = DEF_ROWS,
    parameter int  COLS = DEF_COLS,
    localparam int HW   = $clog2(num_rects(ROWS, COLS) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*COLS-1:0] m_in,
    input  logic                 flip_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROWS*COLS-1:0] m_out,
    output logic [HW-1:0]        hit_count,
    output logic                 busy
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_t                state_q, state_nxt;
    logic [ROWS*COLS-1:0]  matrix_q, matrix_nxt;
    logic [HW-1:0]         hits_q, hits_nxt;
    logic [RW-1:0]         r1_q, r1_nxt, r2_q, r2_nxt;
    logic [CW-1:0]         c1_q, c1_nxt, c2_q, c2_nxt;
    logic                  flip_q, flip_nxt;
    logic [ROWS*COLS-1:0]  mask;
    logic                  hit;

    rect_mask #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_mask (
        .r1   (r1_q),
        .r2   (r2_q),
        .c1   (c1_q),
        .c2   (c2_q),
        .mask (mask)
    );

    assign hit       = ((matrix_q & mask) == mask);
    assign m_out     = matrix_q;
    assign hit_count = hits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            hits_q   <= '0;
            r1_q     <= '0;
            r2_q     <= RW'(1);
            c1_q     <= '0;
            c2_q     <= CW'(1);
            flip_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            matrix_q <= matrix_nxt;
            hits_q   <= hits_nxt;
            r1_q     <= r1_nxt;
            r2_q     <= r2_nxt;
            c1_q     <= c1_nxt;
            c2_q     <= c2_nxt;
            flip_q   <= flip_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        matrix_nxt = matrix_q;
        hits_nxt   = hits_q;
        r1_nxt     = r1_q;
        r2_nxt     = r2_q;
        c1_nxt     = c1_q;
        c2_nxt     = c2_q;
        flip_nxt   = flip_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    matrix_nxt = m_in;
                    flip_nxt   = flip_mode;
                    hits_nxt   = '0;
                    r1_nxt     = '0;
                    r2_nxt     = RW'(1);
                    c1_nxt     = '0;
                    c2_nxt     = CW'(1);
                    state_nxt  = SCAN;
                end
            end

            SCAN: begin
                busy = 1'b1;
                if (hit) begin
                    hits_nxt = hits_q + HW'(1);
                    if (flip_q) matrix_nxt = matrix_q ^ mask;
                end
                // c2 innermost, r1 outermost; each inner pair restarts just past its outer index
                if (c2_q != CW'(COLS - 1)) begin
                    c2_nxt = c2_q + CW'(1);
                end else if (c1_q != CW'(COLS - 2)) begin
                    c1_nxt = c1_q + CW'(1);
                    c2_nxt = c1_q + CW'(2);
                end else if (r2_q != RW'(ROWS - 1)) begin
                    r2_nxt = r2_q + RW'(1);
                    c1_nxt = '0;
                    c2_nxt = CW'(1);
                end else if (r1_q != RW'(ROWS - 2)) begin
                    r1_nxt = r1_q + RW'(1);
                    r2_nxt = r1_q + RW'(2);
                    c1_nxt = '0;
                    c2_nxt = CW'(1);
                end else begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rect_scan_ctrl.sv
// tb/tb_rect_scan_ctrl.sv - directed table-driven bench for rect_scan_ctrl
module tb_rect_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;
    localparam int LAT  = 37;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] m_in = '0;
    logic         flip_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] m_out;
    logic [5:0]   hit_count;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] m;
        logic        flip;
        int          exp_hits;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vecs[8];

    rect_scan_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_in      (m_in),
        .flip_mode (flip_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_out     (m_out),
        .hit_count (hit_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] m, input logic f);
        @(negedge clk);
        m_in      = m;
        flip_mode = f;
        in_valid  = 1'b1;
        check("in_ready_before_load", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Called at the negedge after the handshake edge T; returns k such that out_valid
    // is first seen high by a consumer sampling at edge T+k (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        load(v.m, v.flip);
        wait_done(lat);
        check("latency", 32'(lat), 32'(LAT));
        check("hit_count", 32'(hit_count), 32'(v.exp_hits));
        check("m_out", 32'(m_out), 32'(v.exp_m));
        release_result();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{16'h0000, 1'b0,  0, 16'h0000};
        vecs[1] = '{16'hFFFF, 1'b0, 36, 16'hFFFF};
        vecs[2] = '{16'hFFFF, 1'b1,  4, 16'h0000};
        vecs[3] = '{16'h9009, 1'b1,  1, 16'h0000};
        vecs[4] = '{16'h0033, 1'b0,  1, 16'h0033};
        vecs[5] = '{16'h00FF, 1'b0,  6, 16'h00FF};
        vecs[6] = '{16'h00FF, 1'b1,  2, 16'h0000};
        vecs[7] = '{16'h0013, 1'b1,  0, 16'h0013};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_out", 32'(m_out), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Flip visible on m_out after the first scan edge, then reset deep in SCAN.
        load(16'hFFFF, 1'b1);
        @(negedge clk);
        check("scan_m_out_first_flip", 32'(m_out), 32'h0000FFCC);
        check("scan_busy", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_m_out", 32'(m_out), 32'd0);
        check("midrst_hit_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[2]);

        // Hold in DONE with a competing load request.
        load(16'hFFFF, 1'b0);
        wait_done(lat);
        check("hold_latency", 32'(lat), 32'(LAT));
        m_in      = 16'h0000;
        flip_mode = 1'b1;
        in_valid  = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_hit_count", 32'(hit_count), 32'd36);
        check("hold_m_out", 32'(m_out), 32'h0000FFFF);
        check("hold_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        release_result();
        check("hold_no_reload", 32'(m_out), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rect_scan_ctrl.md
RECT_SCAN_CTRL -- requirements
Module: rect_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows (>=2).
REQ-002 Parameter COLS, default 4, number of matrix columns (>=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  load request.
REQ-006 in_ready  output  1  block can accept a load.
REQ-007 m_in  input  ROWS*COLS  matrix to load; bit index row*COLS+col.
REQ-008 flip_mode  input  1  sampled at load: 0 = count only, 1 = count and flip each hit rectangle.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  result consumer ready.
REQ-011 m_out  output  ROWS*COLS  working matrix register, same bit layout as m_in.
REQ-012 hit_count  output  $clog2(NUM_RECTS+1)  number of hits in the current or last scan.
REQ-013 busy  output  1  high while in SCAN.

Function
REQ-014 NUM_RECTS SHALL equal C(ROWS,2)*C(COLS,2); 36 at defaults.
REQ-015 FSM states SHALL be IDLE, SCAN, DONE.
REQ-016 IDLE: in_ready=1; in_valid&&in_ready SHALL load m_in into the matrix register, latch flip_mode, clear hit_count, set coordinates to (r1,r2,c1,c2)=(0,1,0,1), and go to SCAN.
REQ-017 SCAN: one candidate per cycle; hit = all four corner bits (r1,c1),(r1,c2),(r2,c1),(r2,c2) equal 1 in the current matrix register.
REQ-018 On hit: hit_count SHALL increment; if latched flip_mode=1, the matrix register SHALL be XORed with the four-corner mask in the same edge.
REQ-019 Later candidates SHALL be evaluated on the already-updated matrix.
REQ-020 Coordinate order: r1 0..ROWS-2, r2 r1+1..ROWS-1, c1 0..COLS-2, c2 c1+1..COLS-1; c2 innermost, r1 outermost.
REQ-021 After evaluating (ROWS-2,ROWS-1,COLS-2,COLS-1) the FSM SHALL go to DONE; no coordinate wrap-around is evaluated twice.
REQ-022 Latency: load handshake at edge T -> SCAN for exactly NUM_RECTS cycles -> out_valid=1 from edge T+NUM_RECTS+1 (T+37 at defaults).
REQ-023 DONE: out_valid=1, in_ready=0; m_out and hit_count SHALL stay stable until out_valid&&out_ready, then IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-025 hit_count SHALL never saturate or wrap (width fits NUM_RECTS).
REQ-026 m_out SHALL always reflect the matrix register, including during SCAN.

Reset
REQ-027 rst asserted SHALL asynchronously force IDLE, matrix register=0, hit_count=0, coordinates=(0,1,0,1), latched mode=0.
REQ-028 Reset outputs: in_ready=1 after rst deasserts, out_valid=0, busy=0, m_out=0, hit_count=0.
REQ-029 Reset mid-SCAN or mid-DONE SHALL discard the scan with no residual output.

Structure
REQ-030 Shared package rect_pkg SHALL hold ROWS/COLS defaults, NUM_RECTS, coordinate typedef ($clog2 width), and the FSM state enum.
REQ-031 One combinational sub-module rect_mask SHALL produce the ROWS*COLS four-corner mask from (r1,r2,c1,c2); the controller SHALL use it for both hit test and flip.

Verification
REQ-032 m_in=0, flip_mode=0 -> hit_count=0, m_out=0, out_valid exactly 37 cycles after load handshake.
REQ-033 m_in all ones, flip_mode=0 -> hit_count=36, m_out all ones.
REQ-034 m_in all ones, flip_mode=1 -> hits at (0,1,0,1),(0,1,2,3),(2,3,0,1),(2,3,2,3) only; hit_count=4, m_out=0.
REQ-035 m_in with only bits (0,0),(0,3),(3,0),(3,3) set, flip_mode=1 -> hit_count=1, m_out=0.
REQ-036 DONE with out_ready low 5 cycles and in_valid high -> out_valid, m_out, hit_count held, in_ready=0, no reload; out_ready high -> IDLE next cycle.
REQ-037 rst pulse at SCAN cycle 10 -> immediately out_valid=0, busy=0, m_out=0, hit_count=0; new load then completes normally.
